apb_rr_arbiter: RTL and testbench



---
 rtl/apb_rr_arbiter.sv | 126 ++++++++++++
 tb/tb_apb_rr_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_rr_arbiter.sv
// Round-robin sharing of one APB master port among NUM_REQ requesters; 1 arbitration + 1 SETUP cycle before ACCESS.
// Losing requesters wait with PREADY low; a watchdog error-completes ACCESS phases that exceed TIMEOUT_CYCLES.
module apb_rr_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_REQ-1:0]                req_psel_i,
  input  logic [NUM_REQ-1:0]                req_penable_i,
  input  logic [NUM_REQ-1:0]                req_pwrite_i,
  input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0] req_paddr_i,
  input  logic [NUM_REQ*APB_DATA_WIDTH-1:0] req_pwdata_i,
  output logic [NUM_REQ-1:0]                req_pready_o,
  output logic [APB_DATA_WIDTH-1:0]         req_prdata_o,
  output logic                              req_pslverr_o,
  output logic                              m_psel_o,
  output logic                              m_penable_o,
  output logic                              m_pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0]         m_paddr_o,
  output logic [APB_DATA_WIDTH-1:0]         m_pwdata_o,
  input  logic [APB_DATA_WIDTH-1:0]         m_prdata_i,
  input  logic                              m_pready_i,
  input  logic                              m_pslverr_i,
  output logic [NUM_REQ-1:0]                grant_o,
  output logic                              timeout_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   gnt_idx;
  logic [CNT_W-1:0]   cnt;
  logic               win_vld;
  logic [IDX_W-1:0]   win_idx;
  int                 cand;
  logic               in_access;
  logic               tmo_hit;
  logic               done;

  // Search starts one past the last owner so the previous winner is considered last.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!win_vld && req_psel_i[IDX_W'(cand)]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(cand);
      end
    end
  end

  // Completion is combinational so the requester sees PREADY in the slave's PREADY cycle.
  always_comb begin
    in_access     = (state == S_ACCESS) && !rst_i;
    tmo_hit       = (TIMEOUT_CYCLES != 0) && in_access && !m_pready_i &&
                    (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    done          = in_access && (m_pready_i || tmo_hit);
    req_pready_o  = done ? grant_o : '0;
    req_prdata_o  = (in_access && m_pready_i) ? m_prdata_i : '0;
    req_pslverr_o = (in_access && m_pready_i) ? m_pslverr_i : tmo_hit;
    timeout_o     = tmo_hit;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      ptr         <= IDX_W'(NUM_REQ - 1);
      gnt_idx     <= '0;
      grant_o     <= '0;
      cnt         <= '0;
      m_psel_o    <= 1'b0;
      m_penable_o <= 1'b0;
      m_pwrite_o  <= 1'b0;
      m_paddr_o   <= '0;
      m_pwdata_o  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_vld) begin
            gnt_idx    <= win_idx;
            grant_o    <= NUM_REQ'(1) << win_idx;
            m_psel_o   <= 1'b1;
            m_pwrite_o <= req_pwrite_i[win_idx];
            m_paddr_o  <= req_paddr_i[win_idx*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
            m_pwdata_o <= req_pwdata_i[win_idx*APB_DATA_WIDTH +: APB_DATA_WIDTH];
            state      <= S_SETUP;
          end
        end
        S_SETUP: begin
          m_penable_o <= 1'b1;
          cnt         <= '0;
          state       <= S_ACCESS;
        end
        S_ACCESS: begin
          if (done) begin
            ptr         <= gnt_idx;
            grant_o     <= '0;
            cnt         <= '0;
            m_psel_o    <= 1'b0;
            m_penable_o <= 1'b0;
            m_pwrite_o  <= 1'b0;
            m_paddr_o   <= '0;
            m_pwdata_o  <= '0;
            state       <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic unused_penable;
  assign unused_penable = ^req_penable_i;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Scoreboard bench for apb_rr_arbiter: randomized requesters, address-keyed slave model, rr predictor.
module tb_apb_rr_arbiter;

  localparam int NR  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] rdata;
    logic          err;
    logic          tmo;
    int            ncyc;
  } txn_t;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic [NR-1:0]     psel_v = '0, pen_v = '0, pwrite_v = '0;
  logic [NR*AW-1:0]  paddr_v = '0;
  logic [NR*DW-1:0]  pwdata_v = '0;
  logic [NR-1:0]     req_pready_o;
  logic [DW-1:0]     req_prdata_o;
  logic              req_pslverr_o;
  logic              m_psel_o, m_penable_o, m_pwrite_o;
  logic [AW-1:0]     m_paddr_o;
  logic [DW-1:0]     m_pwdata_o;
  logic [DW-1:0]     m_prdata_i = '0;
  logic              m_pready_i = 1'b0, m_pslverr_i = 1'b0;
  logic [NR-1:0]     grant_o;
  logic              timeout_o;

  txn_t          exp_q [NR][$];
  logic [NR-1:0] busy = '0;
  int            checks = 0, errors = 0;

  always #5 clk = ~clk;

  apb_rr_arbiter #(.NUM_REQ(NR), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_psel_i(psel_v), .req_penable_i(pen_v), .req_pwrite_i(pwrite_v),
    .req_paddr_i(paddr_v), .req_pwdata_i(pwdata_v),
    .req_pready_o(req_pready_o), .req_prdata_o(req_prdata_o), .req_pslverr_o(req_pslverr_o),
    .m_psel_o(m_psel_o), .m_penable_o(m_penable_o), .m_pwrite_o(m_pwrite_o),
    .m_paddr_o(m_paddr_o), .m_pwdata_o(m_pwdata_o),
    .m_prdata_i(m_prdata_i), .m_pready_i(m_pready_i), .m_pslverr_i(m_pslverr_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Slave behaviour is a pure function of the address: [7:4] wait states, [8] slave error, data = ~addr.
  function automatic int waits_of(input logic [AW-1:0] a);
    return int'(a[7:4]);
  endfunction

  function automatic int predict(input logic [NR-1:0] p, input int last);
    for (int k = 1; k <= NR; k++) begin
      if (p[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  task automatic issue(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    txn_t t;
    int   w;
    w       = waits_of(a);
    t.wr    = wr;
    t.addr  = a;
    t.data  = d;
    t.tmo   = (w >= TMO);
    t.ncyc  = t.tmo ? TMO : w + 1;
    t.rdata = t.tmo ? '0 : ~a;
    t.err   = t.tmo ? 1'b1 : a[8];
    exp_q[i].push_back(t);
    psel_v[i] = 1'b1;
    pen_v[i]  = 1'b0;
    pwrite_v[i] = wr;
    paddr_v[i*AW +: AW]  = a;
    pwdata_v[i*DW +: DW] = d;
    busy[i] = 1'b1;
  endtask

  task automatic issue_rand(input int i);
    logic [AW-1:0] a;
    a      = $urandom;
    a[8]   = 1'($urandom_range(1));
    a[7:4] = 4'($urandom_range(5));
    a[3:0] = 4'h0;
    issue(i, 1'($urandom_range(1)), a, $urandom);
  endtask

  // One requester-side cycle: retire completed requests, raise PENABLE, optionally issue new ones.
  task automatic step(input logic [NR-1:0] gen_mask, input int pct);
    logic [NR-1:0] rdy;
    @(negedge clk);
    rdy = req_pready_o;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (busy[i] && rdy[i]) begin
        busy[i] = 1'b0;
        psel_v[i] = 1'b0;
        pen_v[i]  = 1'b0;
      end else if (busy[i]) begin
        pen_v[i] = 1'b1;
      end
      if (gen_mask[i] && !busy[i] && ($urandom_range(99) < pct)) issue_rand(i);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy != '0 && n < 300) begin
      step('0, 0);
      n++;
    end
    chk("drain_all_served", 64'(busy), 64'(0));
  endtask

  // Slave: PREADY after the address-encoded number of wait states; random noise otherwise.
  initial begin : slave
    int acc;
    acc = 0;
    forever begin
      @(posedge clk);
      #1;
      acc = (m_psel_o && m_penable_o) ? acc + 1 : 0;
      if (acc > 0 && acc == waits_of(m_paddr_o) + 1) begin
        m_pready_i  = 1'b1;
        m_prdata_i  = ~m_paddr_o;
        m_pslverr_i = m_paddr_o[8];
      end else begin
        m_pready_i  = 1'b0;
        m_prdata_i  = $urandom;
        m_pslverr_i = 1'($urandom_range(1));
      end
    end
  end

  initial begin : monitor
    int   last_w, prev_win, cur, acc_n, exp_acc;
    bit   prev_rst, prev_idle, prev_done;
    txn_t t;
    last_w = NR - 1; prev_win = -1; cur = -1; acc_n = 0; exp_acc = 0;
    prev_rst = 1'b0; prev_idle = 1'b0; prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        chk("rst_pready", 64'(req_pready_o), 64'(0));
        if (prev_rst)
          chk("rst_outputs", {grant_o, m_psel_o, m_penable_o, timeout_o, req_pslverr_o}, 64'(0));
        last_w = NR - 1; prev_win = -1; cur = -1; acc_n = 0;
        prev_idle = 1'b0; prev_done = 1'b0; prev_rst = 1'b1;
        continue;
      end
      prev_rst = 1'b0;
      if (prev_idle) begin
        if (prev_win >= 0) begin
          chk("setup_grant", 64'(grant_o), 64'(1) << prev_win);
          chk("setup_phase", {m_psel_o, m_penable_o}, 64'b10);
          chk("setup_queued", 64'(exp_q[prev_win].size() != 0), 64'(1));
          if (exp_q[prev_win].size() != 0) begin
            t = exp_q[prev_win][0];
            chk("setup_paddr", 64'(m_paddr_o), 64'(t.addr));
            chk("setup_pwdata", 64'(m_pwdata_o), 64'(t.data));
            chk("setup_pwrite", 64'(m_pwrite_o), 64'(t.wr));
            exp_acc = t.ncyc;
          end
          cur = prev_win; last_w = prev_win; acc_n = 0;
        end else begin
          chk("idle_stays_idle", {grant_o, m_psel_o}, 64'(0));
        end
      end
      if (prev_done) chk("after_done_psel", 64'(m_psel_o), 64'(0));
      if (!m_psel_o) begin
        chk("idle_master_zero", {m_penable_o, m_pwrite_o, m_paddr_o, m_pwdata_o[DW-1:2]}, 64'(0));
        chk("idle_grant_zero", 64'(grant_o), 64'(0));
        prev_win  = predict(psel_v, last_w);
        prev_idle = 1'b1;
      end else begin
        prev_idle = 1'b0;
      end
      if (m_psel_o && m_penable_o) acc_n++;
      if (req_pready_o != '0) begin
        chk("done_pready_is_grant", 64'(req_pready_o), 64'(grant_o));
        chk("done_owner", 64'(req_pready_o), (cur >= 0) ? (64'(1) << cur) : 64'(0));
        chk("done_cycle", 64'(acc_n), 64'(exp_acc));
        if (cur >= 0 && exp_q[cur].size() != 0) begin
          t = exp_q[cur].pop_front();
          chk("done_prdata", 64'(req_prdata_o), 64'(t.rdata));
          chk("done_pslverr", 64'(req_pslverr_o), 64'(t.err));
          chk("done_timeout", 64'(timeout_o), 64'(t.tmo));
        end else begin
          chk("done_unexpected", 64'(1), 64'(0));
        end
        prev_done = 1'b1;
      end else begin
        chk("quiet_resp_zero", {req_prdata_o, req_pslverr_o, timeout_o}, 64'(0));
        if (m_psel_o && m_penable_o) chk("access_not_overdue", 64'(acc_n < exp_acc), 64'(1));
        prev_done = 1'b0;
      end
    end
  end

  initial begin : stimulus
    int n;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    step('0, 0);

    // Single zero-wait write from requester 0.
    issue(0, 1'b1, 32'h1A10_0004, 32'hDEAD_BEEF);
    drain();

    // Simultaneous requests, then continuous requesting from 0 and 1.
    issue(0, 1'b0, 32'h0000_1000, 32'h1);
    issue(1, 1'b1, 32'h0000_2010, 32'h2);
    repeat (12) step(4'b0011, 100);
    drain();

    // Requester 1 read with 3 wait states and slave error; requester 0 contends.
    issue(1, 1'b0, 32'h0000_0130, 32'h0);
    issue(0, 1'b1, 32'h0000_0400, 32'h5555_AAAA);
    drain();

    // Watchdog expiry, then the boundary where PREADY lands on the last allowed cycle.
    issue(2, 1'b1, 32'h0000_0050, 32'hCAFE_0001);
    drain();
    issue(2, 1'b0, 32'h0000_0030, 32'h0);
    drain();

    // Reset during ACCESS.
    issue(2, 1'b1, 32'h2000_0050, 32'h1234_5678);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m_psel_o && m_penable_o) && n < 20);
    chk("reached_access", 64'(m_psel_o && m_penable_o), 64'(1));
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    psel_v = '0; pen_v = '0; busy = '0;
    for (int i = 0; i < NR; i++) exp_q[i].delete();
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    issue(3, 1'b1, 32'h0000_0300, 32'h3);
    issue(0, 1'b1, 32'h0000_0000, 32'h4);
    drain();

    // Pointer at 1 with requesters 1 and 3 pending.
    issue(1, 1'b1, 32'h0000_0010, 32'h5);
    drain();
    issue(1, 1'b0, 32'h0000_0020, 32'h0);
    issue(3, 1'b0, 32'h0000_0000, 32'h0);
    drain();

    // Randomized traffic on all requesters.
    repeat (400) step('1, 35);
    drain();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
